pong_axil_regs: RTL and testbench
=================================

PONG_AXIL_REGS -- requirements
Module: pong_axil_regs

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width; four 32-bit registers.
REQ-003 s00_axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-004 s00_axi_aresetn  in  1  reset, synchronous, active-low.
REQ-005 s00_axi_awaddr  in  4  write address; s00_axi_awprot  in  3  ignored.
REQ-006 s00_axi_awvalid  in  1 / s00_axi_awready  out  1  write-address handshake.
REQ-007 s00_axi_wdata  in  32 / s00_axi_wstrb  in  4 / s00_axi_wvalid  in  1 / s00_axi_wready  out  1  write-data channel.
REQ-008 s00_axi_bresp  out  2 / s00_axi_bvalid  out  1 / s00_axi_bready  in  1  write-response channel.
REQ-009 s00_axi_araddr  in  4 / s00_axi_arprot  in  3 (ignored) / s00_axi_arvalid  in  1 / s00_axi_arready  out  1  read-address channel.
REQ-010 s00_axi_rdata  out  32 / s00_axi_rresp  out  2 / s00_axi_rvalid  out  1 / s00_axi_rready  in  1  read-data channel.
REQ-011 slv_reg0..slv_reg3  out  32 each  current register contents to pong core (paddle/ball control).
REQ-012 reg_wr_pulse  out  4  one-cycle pulse, bit n set in the cycle after register n is written.

Function
REQ-013 Decode on addr[3:2]: 0x0 reg0, 0x4 reg1, 0x8 reg2, 0xC reg3; addr[1:0] ignored.
REQ-014 Write accept: awready and wready both assert for exactly one cycle when awvalid && wvalid && !awready && !bvalid; AW alone or W alone is never accepted.
REQ-015 Register update occurs on the clock edge that completes the AW/W handshake; new value visible on slv_regN next cycle.
REQ-016 bvalid asserts in the cycle after write accept, bresp = 2'b00; held until bready sampled high, then deasserts next cycle.
REQ-017 No new write accepted while bvalid is high (single outstanding write).
REQ-018 Read accept: arready asserts for one cycle when arvalid && !arready && !rvalid.
REQ-019 rdata registered from the addressed register at the AR handshake edge; rvalid asserts next cycle, rresp = 2'b00, both rvalid and rdata held stable until rready sampled high.
REQ-020 No new read accepted while rvalid is high (single outstanding read).
REQ-021 Read and write channels independent; simultaneous AR and AW/W handshake to same register returns pre-write value on rdata.
REQ-022 reg_wr_pulse bit n high exactly one cycle per accepted write to register n; zero otherwise.
REQ-023 bvalid and rvalid set/clear with bready/rready as 2-state FSMs each: IDLE -> RESP on accept, RESP -> IDLE on ready.

Reset
REQ-024 While s00_axi_aresetn low at a clock edge: all slv_regN = 0, awready, wready, arready, bvalid, rvalid = 0, bresp, rresp = 0, rdata = 0, reg_wr_pulse = 0.
REQ-025 Reset asserted mid-transaction aborts it: pending bvalid/rvalid dropped without handshake; register written in the same edge as reset keeps reset value 0.
REQ-026 First transaction accepted no earlier than first edge after aresetn sampled high.

Configuration
REQ-027 Macro PONG_AXIL_WSTRB_EN defined: only bytes with wstrb[k]=1 updated (byte k = bits 8k+7:8k); undefined: wstrb ignored, full 32-bit word always written.

Verification
REQ-028 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, read back in order -> rdata 0x1,0x2,0x3,0x4, all bresp/rresp 00, reg_wr_pulse 0001,0010,0100,1000.
REQ-029 With PONG_AXIL_WSTRB_EN: reg1=0xAABBCCDD, write 0x11223344 wstrb 0101 -> reg1 = 0xAA22CC44; without macro -> 0x11223344.
REQ-030 Write 0x55 to 0x8 with bready held low 5 cycles -> bvalid high 5+ cycles, second AW/W presented meanwhile not accepted until bready handshake completes.
REQ-031 AW valid 3 cycles before W valid -> awready stays low until wvalid high, then awready/wready pulse together once.
REQ-032 Same-cycle read and write of 0xC (old 0x4, new 0x9) -> rdata 0x4, subsequent read 0x9.
REQ-033 Assert aresetn low while rvalid high with rready low -> next cycle rvalid 0, all slv_regN 0, rdata 0.

Source files
------------

// File: rtl/pong_axil_regs_if.sv
// AXI4-Lite bus bundle for the pong register block.
// The master modport drives the requests and the slave modport drives the responses.
interface pong_axil_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr;
  logic [2:0]                        s00_axi_awprot;
  logic                              s00_axi_awvalid;
  logic                              s00_axi_awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata;
  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb;
  logic                              s00_axi_wvalid;
  logic                              s00_axi_wready;
  logic [1:0]                        s00_axi_bresp;
  logic                              s00_axi_bvalid;
  logic                              s00_axi_bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr;
  logic [2:0]                        s00_axi_arprot;
  logic                              s00_axi_arvalid;
  logic                              s00_axi_arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata;
  logic [1:0]                        s00_axi_rresp;
  logic                              s00_axi_rvalid;
  logic                              s00_axi_rready;

  modport slave (
    input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    output s00_axi_awready,
    input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    output s00_axi_wready,
    output s00_axi_bresp, s00_axi_bvalid,
    input  s00_axi_bready,
    input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    output s00_axi_arready,
    output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    input  s00_axi_rready
  );

  modport master (
    output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    input  s00_axi_awready,
    output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    input  s00_axi_wready,
    input  s00_axi_bresp, s00_axi_bvalid,
    output s00_axi_bready,
    output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    input  s00_axi_arready,
    input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    output s00_axi_rready
  );
endinterface

// File: rtl/pong_axil_regs.sv
// AXI4-Lite slave that holds four 32-bit control registers for the pong core.
// It accepts one outstanding write and one outstanding read. Defining PONG_AXIL_WSTRB_EN enables byte-lane writes through wstrb.
module pong_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_aresetn,
  pong_axil_regs_if.slave               axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg3,
  output logic [3:0]                    reg_wr_pulse
);
  typedef enum logic {RESP_IDLE = 1'b0, RESP_BUSY = 1'b1} resp_state_t;

  resp_state_t                   b_state_r, b_state_next_s;
  resp_state_t                   r_state_r, r_state_next_s;
  logic                          awready_r, arready_r;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_r;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_r [4];
  logic [3:0]                    pulse_r;
  logic                          wr_hs_s, rd_hs_s;
  logic [1:0]                    wr_idx_s, rd_idx_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_word_s;
  logic                          unused_bits_s;

  assign wr_idx_s = axi.s00_axi_awaddr[3:2];
  assign rd_idx_s = axi.s00_axi_araddr[3:2];
  assign wr_hs_s  = awready_r & axi.s00_axi_awvalid & axi.s00_axi_wvalid;
  assign rd_hs_s  = arready_r & axi.s00_axi_arvalid;

`ifdef PONG_AXIL_WSTRB_EN
  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] merge_bytes(
    input logic [C_S_AXI_DATA_WIDTH-1:0]     cur,
    input logic [C_S_AXI_DATA_WIDTH-1:0]     wdat,
    input logic [(C_S_AXI_DATA_WIDTH/8)-1:0] strb
  );
    logic [C_S_AXI_DATA_WIDTH-1:0] res;
    res = cur;
    for (int k = 0; k < C_S_AXI_DATA_WIDTH/8; k++) begin
      if (strb[k]) begin
        res[8*k +: 8] = wdat[8*k +: 8];
      end
    end
    return res;
  endfunction

  assign wr_word_s = merge_bytes(regs_r[wr_idx_s], axi.s00_axi_wdata, axi.s00_axi_wstrb);
`else
  assign wr_word_s = axi.s00_axi_wdata;
`endif

  // Protection bits and byte offsets carry no meaning for this block.
  assign unused_bits_s = ^{axi.s00_axi_awprot, axi.s00_axi_arprot, axi.s00_axi_awaddr[1:0],
                           axi.s00_axi_araddr[1:0], axi.s00_axi_wstrb};

  // awready and wready pulse together only when AW and W are both valid and no response is pending.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      awready_r <= 1'b0;
      arready_r <= 1'b0;
    end else begin
      awready_r <= axi.s00_axi_awvalid & axi.s00_axi_wvalid & ~awready_r & (b_state_r == RESP_IDLE);
      arready_r <= axi.s00_axi_arvalid & ~arready_r & (r_state_r == RESP_IDLE);
    end
  end

  // Response-channel state registers.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      b_state_r <= RESP_IDLE;
      r_state_r <= RESP_IDLE;
    end else begin
      b_state_r <= b_state_next_s;
      r_state_r <= r_state_next_s;
    end
  end

  // Response-channel next-state logic.
  always_comb begin
    b_state_next_s = b_state_r;
    r_state_next_s = r_state_r;
    case (b_state_r)
      RESP_IDLE: if (wr_hs_s) b_state_next_s = RESP_BUSY; else b_state_next_s = RESP_IDLE;
      RESP_BUSY: if (axi.s00_axi_bready) b_state_next_s = RESP_IDLE; else b_state_next_s = RESP_BUSY;
      default:   b_state_next_s = RESP_IDLE;
    endcase
    case (r_state_r)
      RESP_IDLE: if (rd_hs_s) r_state_next_s = RESP_BUSY; else r_state_next_s = RESP_IDLE;
      RESP_BUSY: if (axi.s00_axi_rready) r_state_next_s = RESP_IDLE; else r_state_next_s = RESP_BUSY;
      default:   r_state_next_s = RESP_IDLE;
    endcase
  end

  // Register file, write pulse and read data; a read racing a write to the same register sees the old value.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < 4; i++) regs_r[i] <= '0;
      pulse_r <= 4'b0000;
      rdata_r <= '0;
    end else begin
      pulse_r <= 4'b0000;
      if (wr_hs_s) begin
        regs_r[wr_idx_s]  <= wr_word_s;
        pulse_r[wr_idx_s] <= 1'b1;
      end
      if (rd_hs_s) begin
        rdata_r <= regs_r[rd_idx_s];
      end
    end
  end

  assign axi.s00_axi_awready = awready_r;
  assign axi.s00_axi_wready  = awready_r;
  assign axi.s00_axi_bvalid  = (b_state_r == RESP_BUSY);
  assign axi.s00_axi_bresp   = 2'b00;
  assign axi.s00_axi_arready = arready_r;
  assign axi.s00_axi_rvalid  = (r_state_r == RESP_BUSY);
  assign axi.s00_axi_rresp   = 2'b00;
  assign axi.s00_axi_rdata   = rdata_r;
  assign slv_reg0            = regs_r[0];
  assign slv_reg1            = regs_r[1];
  assign slv_reg2            = regs_r[2];
  assign slv_reg3            = regs_r[3];
  assign reg_wr_pulse        = pulse_r;
endmodule

// File: tb/tb_pong_axil_regs.sv
// Directed testbench for pong_axil_regs.
// Checks reset, writes and reads, byte strobes, backpressure, channel ordering, same-cycle read/write and mid-read reset.
module tb_pong_axil_regs;
  logic        clk;
  logic        aresetn;
  logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
  logic [3:0]  reg_wr_pulse;
  int          compared;
  int          mismatched;
  int          n;

`ifdef PONG_AXIL_WSTRB_EN
  localparam logic [31:0] EXP_STRB = 32'hAA22CC44;
`else
  localparam logic [31:0] EXP_STRB = 32'h11223344;
`endif

  pong_axil_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

  pong_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (aresetn),
    .axi             (bus),
    .slv_reg0        (slv_reg0),
    .slv_reg1        (slv_reg1),
    .slv_reg2        (slv_reg2),
    .slv_reg3        (slv_reg3),
    .reg_wr_pulse    (reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int k;
    @(negedge clk);
    bus.s00_axi_awaddr  = addr;
    bus.s00_axi_awvalid = 1'b1;
    bus.s00_axi_wdata   = data;
    bus.s00_axi_wstrb   = strb;
    bus.s00_axi_wvalid  = 1'b1;
    k = 0;
    while (bus.s00_axi_awready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("wr_accept_in_time", 1'(k < 20), 1'b1);
    chk("wready_with_awready", bus.s00_axi_wready, 1'b1);
    @(posedge clk); #1;
    bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wvalid  = 1'b0;
    @(negedge clk);
    chk("bvalid_set", bus.s00_axi_bvalid, 1'b1);
    chk("bresp_okay", bus.s00_axi_bresp, 2'b00);
    chk("wr_pulse", reg_wr_pulse, 4'b0001 << addr[3:2]);
    bus.s00_axi_bready = 1'b1;
    @(posedge clk); #1;
    bus.s00_axi_bready = 1'b0;
    @(negedge clk);
    chk("bvalid_clear", bus.s00_axi_bvalid, 1'b0);
    chk("wr_pulse_clear", reg_wr_pulse, 4'b0000);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    int k;
    @(negedge clk);
    bus.s00_axi_araddr  = addr;
    bus.s00_axi_arvalid = 1'b1;
    k = 0;
    while (bus.s00_axi_arready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rd_accept_in_time", 1'(k < 20), 1'b1);
    @(posedge clk); #1;
    bus.s00_axi_arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid_set", bus.s00_axi_rvalid, 1'b1);
    chk("rresp_okay", bus.s00_axi_rresp, 2'b00);
    chk(tag, bus.s00_axi_rdata, exp);
    bus.s00_axi_rready = 1'b1;
    @(posedge clk); #1;
    bus.s00_axi_rready = 1'b0;
    @(negedge clk);
    chk("rvalid_clear", bus.s00_axi_rvalid, 1'b0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    aresetn    = 1'b0;
    bus.s00_axi_awaddr  = 4'h0;
    bus.s00_axi_awprot  = 3'b000;
    bus.s00_axi_awvalid = 1'b1;
    bus.s00_axi_wdata   = 32'hDEADBEEF;
    bus.s00_axi_wstrb   = 4'hF;
    bus.s00_axi_wvalid  = 1'b1;
    bus.s00_axi_bready  = 1'b0;
    bus.s00_axi_araddr  = 4'h0;
    bus.s00_axi_arprot  = 3'b000;
    bus.s00_axi_arvalid = 1'b1;
    bus.s00_axi_rready  = 1'b0;

    // Reset with requests pending: nothing may be accepted or stored.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_regs", {slv_reg0, slv_reg1, slv_reg2, slv_reg3}, 128'd0);
    chk("rst_ready", {bus.s00_axi_awready, bus.s00_axi_wready, bus.s00_axi_arready}, 3'b000);
    chk("rst_valid", {bus.s00_axi_bvalid, bus.s00_axi_rvalid}, 2'b00);
    chk("rst_resp", {bus.s00_axi_bresp, bus.s00_axi_rresp}, 4'b0000);
    chk("rst_rdata", bus.s00_axi_rdata, 32'd0);
    chk("rst_pulse", reg_wr_pulse, 4'b0000);
    bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wvalid  = 1'b0;
    bus.s00_axi_arvalid = 1'b0;
    aresetn = 1'b1;

    // Basic write then read-back of every register.
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'hC, 32'h4, 4'hF);
    axi_read(4'h0, 32'h1, "rd_reg0");
    axi_read(4'h4, 32'h2, "rd_reg1");
    axi_read(4'h8, 32'h3, "rd_reg2");
    axi_read(4'hD, 32'h4, "rd_reg3_offset_ignored");

    // Byte strobes.
    axi_write(4'h4, 32'hAABBCCDD, 4'hF);
    axi_write(4'h4, 32'h11223344, 4'b0101);
    chk("strb_slv_reg1", slv_reg1, EXP_STRB);
    axi_read(4'h4, EXP_STRB, "rd_strb_reg1");

    // bready held low: the second write must wait for the response handshake.
    @(negedge clk);
    bus.s00_axi_awaddr  = 4'h8;
    bus.s00_axi_wdata   = 32'h55;
    bus.s00_axi_wstrb   = 4'hF;
    bus.s00_axi_awvalid = 1'b1;
    bus.s00_axi_wvalid  = 1'b1;
    n = 0;
    while (bus.s00_axi_awready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_first_accept", 1'(n < 20), 1'b1);
    @(posedge clk); #1;
    bus.s00_axi_awaddr = 4'hC;
    bus.s00_axi_wdata  = 32'h66;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bvalid_held", bus.s00_axi_bvalid, 1'b1);
      chk("bp_no_second_accept", bus.s00_axi_awready, 1'b0);
    end
    chk("bp_slv_reg2", slv_reg2, 32'h55);
    chk("bp_slv_reg3_untouched", slv_reg3, 32'h4);
    bus.s00_axi_bready = 1'b1;
    @(posedge clk); #1;
    bus.s00_axi_bready = 1'b0;
    @(negedge clk);
    chk("bp_bvalid_dropped", bus.s00_axi_bvalid, 1'b0);
    chk("bp_accept_not_early", bus.s00_axi_awready, 1'b0);
    n = 0;
    while (bus.s00_axi_awready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_second_accept", 1'(n < 20), 1'b1);
    @(posedge clk); #1;
    bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wvalid  = 1'b0;
    @(negedge clk);
    chk("bp_slv_reg3", slv_reg3, 32'h66);
    chk("bp_pulse3", reg_wr_pulse, 4'b1000);
    bus.s00_axi_bready = 1'b1;
    @(posedge clk); #1;
    bus.s00_axi_bready = 1'b0;

    // AW arrives three cycles ahead of W.
    @(negedge clk);
    bus.s00_axi_awaddr  = 4'h0;
    bus.s00_axi_wdata   = 32'h77;
    bus.s00_axi_awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("aw_only_not_accepted", bus.s00_axi_awready, 1'b0);
    end
    bus.s00_axi_wvalid = 1'b1;
    @(negedge clk);
    chk("aw_w_accept", {bus.s00_axi_awready, bus.s00_axi_wready}, 2'b11);
    @(posedge clk); #1;
    bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wvalid  = 1'b0;
    @(negedge clk);
    chk("aw_w_single_pulse", {bus.s00_axi_awready, bus.s00_axi_wready}, 2'b00);
    chk("aw_w_slv_reg0", slv_reg0, 32'h77);
    bus.s00_axi_bready = 1'b1;
    @(posedge clk); #1;
    bus.s00_axi_bready = 1'b0;

    // Same-cycle read and write of one register.
    axi_write(4'hC, 32'h4, 4'hF);
    @(negedge clk);
    bus.s00_axi_araddr  = 4'hC;
    bus.s00_axi_arvalid = 1'b1;
    bus.s00_axi_awaddr  = 4'hC;
    bus.s00_axi_wdata   = 32'h9;
    bus.s00_axi_awvalid = 1'b1;
    bus.s00_axi_wvalid  = 1'b1;
    @(negedge clk);
    chk("rw_both_accept", {bus.s00_axi_arready, bus.s00_axi_awready}, 2'b11);
    @(posedge clk); #1;
    bus.s00_axi_arvalid = 1'b0;
    bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wvalid  = 1'b0;
    @(negedge clk);
    chk("rw_rdata_old", bus.s00_axi_rdata, 32'h4);
    chk("rw_valids", {bus.s00_axi_rvalid, bus.s00_axi_bvalid}, 2'b11);
    chk("rw_slv_reg3_new", slv_reg3, 32'h9);
    bus.s00_axi_rready = 1'b1;
    bus.s00_axi_bready = 1'b1;
    @(posedge clk); #1;
    bus.s00_axi_rready = 1'b0;
    bus.s00_axi_bready = 1'b0;
    axi_read(4'hC, 32'h9, "rw_rd_after");

    // Reset while a read response is pending.
    @(negedge clk);
    bus.s00_axi_araddr  = 4'h0;
    bus.s00_axi_arvalid = 1'b1;
    n = 0;
    while (bus.s00_axi_arready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mr_accept", 1'(n < 20), 1'b1);
    @(posedge clk); #1;
    bus.s00_axi_arvalid = 1'b0;
    @(negedge clk);
    chk("mr_rvalid_pending", bus.s00_axi_rvalid, 1'b1);
    chk("mr_rdata_pending", bus.s00_axi_rdata, 32'h77);
    aresetn = 1'b0;
    @(negedge clk);
    chk("mr_rvalid_dropped", bus.s00_axi_rvalid, 1'b0);
    chk("mr_regs_cleared", {slv_reg0, slv_reg1, slv_reg2, slv_reg3}, 128'd0);
    chk("mr_rdata_cleared", bus.s00_axi_rdata, 32'd0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("mr_rvalid_stays_low", bus.s00_axi_rvalid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
